// File: rtl/uart_rx_buffered.sv
// 8N1 serial receiver with a two-flop input synchronizer feeding a
// first-word-fall-through byte FIFO with sticky overflow reporting.
module uart_rx_buffered #(
   parameter int unsigned CLOCK_FREQ = 25000000,
   parameter int unsigned BIT_RATE   = 9600,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             rx,
   input  logic                             rd_en,
   input  logic                             clear_errors,
   output logic [7:0]                       rd_data,
   output logic                             empty,
   output logic                             full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             busy,
   output logic                             frame_error,
   output logic                             overflow
);

   localparam int unsigned BIT_CYCLES  = CLOCK_FREQ / BIT_RATE;
   localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
   localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
   localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
   localparam int unsigned COUNT_W     = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   logic               rx_meta_q, rx_s_q;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               push_c, frame_err_c;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               empty_q, full_q, busy_q, frame_error_q, overflow_q, overflow_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic               pop_ok_c, push_ok_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // Deframer: every timed state counts cnt_q down to zero, then samples rx_s_q.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      push_c      = 1'b0;
      frame_err_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = CNT_W'(HALF_CYCLES - 1);
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
                  cnt_d     = CNT_W'(BIT_CYCLES - 1);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = CNT_W'(BIT_CYCLES - 1);
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s_q) begin
                  push_c  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_c = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping; the head byte is precomputed so rd_data is a flop.
   always_comb begin
      pop_ok_c   = rd_en && !empty_q;
      push_ok_c  = push_c && (!full_q || pop_ok_c);
      head_d     = pop_ok_c  ? head_q + PTR_W'(1) : head_q;
      tail_d     = push_ok_c ? tail_q + PTR_W'(1) : tail_q;
      count_d    = count_q + COUNT_W'(push_ok_c) - COUNT_W'(pop_ok_c);
      overflow_d = overflow_q;
      if (clear_errors)           overflow_d = 1'b0;
      if (push_c && !push_ok_c)   overflow_d = 1'b1;
      if (count_d == '0)                     rd_data_d = 8'h00;
      else if (push_ok_c && head_d == tail_q) rd_data_d = shift_q;
      else                                   rd_data_d = mem_q[head_d];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         rd_data_q     <= '0;
         busy_q        <= 1'b0;
         frame_error_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         if (push_ok_c) mem_q[tail_q] <= shift_q;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         empty_q       <= (count_d == '0);
         full_q        <= (count_d == COUNT_W'(FIFO_DEPTH));
         rd_data_q     <= rd_data_d;
         busy_q        <= (state_d != S_IDLE);
         frame_error_q <= frame_err_c;
         overflow_q    <= overflow_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign count       = count_q;
   assign busy        = busy_q;
   assign frame_error = frame_error_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered, scaled to 16 clocks per bit so the
// fill/overflow scenarios stay short.
module tb_uart_rx_buffered;

   localparam int B = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rd_en = 1'b0;
   logic       clear_errors = 1'b0;
   logic [7:0] rd_data;
   logic       empty, full, busy, frame_error, overflow;
   logic [4:0] count;

   int checks = 0;
   int failures = 0;
   int k = 0;
   int fe_cycles = 0;
   int busy_seen = 0;

   uart_rx_buffered #(.CLOCK_FREQ(160), .BIT_RATE(10), .FIFO_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clear_errors(clear_errors),
      .rd_data(rd_data), .empty(empty), .full(full), .count(count),
      .busy(busy), .frame_error(frame_error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         send;
      logic [7:0] data;
      logic       stop_b;
      bit         pop;
      logic [7:0] exp_rd;
      int         exp_cnt;
      logic       exp_empty;
      int         exp_fe;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      if (frame_error) fe_cycles++;
      if (busy) busy_seen++;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) step();
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_frame_error"}, 32'(frame_error), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   // One 8N1 frame, step counter k counts edges after rx falls.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int hold,
                             input int pop_at, input int abort_at, input bit chk_t);
      logic [9:0] bits;
      int c0;
      bits = {stop_b, d, 1'b0};
      k = 0;
      c0 = int'(count);
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         for (int j = 0; j < B; j++) begin
            step();
            if (k == abort_at) return;
            if (k == pop_at) rd_en = 1'b1;
            if (k == pop_at + 1) rd_en = 1'b0;
            if (chk_t) begin
               if (k == 2) chk("busy_before_start", 32'(busy), 32'd0);
               if (k == 3) chk("busy_at_start", 32'(busy), 32'd1);
               if (k == 154) chk("count_before_push", 32'(count), 32'(c0));
               if (k == 155) begin
                  chk("count_after_push", 32'(count), 32'(c0 + 1));
                  chk("busy_after_push", 32'(busy), 32'd0);
                  chk("rd_after_push", 32'(rd_data), 32'(d));
               end
            end
         end
      end
      repeat (hold) step();
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b1, 0};
      vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1, 1'b0, 0};
      vecs[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h3C, 2, 1'b0, 0};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1, 1'b0, 0};
      vecs[5] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h5A, 1, 1'b0, 1};
      vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h5A, 2, 1'b0, 0};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1, 1'b0, 0};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b1, 0};

      #2 reset = 1'b0;
      #1 chk_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      idle(4);

      // Exact busy/push timing on a single byte
      fe_cycles = 0;
      send_frame(8'hC3, 1'b1, 0, -1, -1, 1'b1);
      idle(6);
      chk("timing_count", 32'(count), 32'd1);
      chk("timing_fe", 32'(fe_cycles), 32'd0);
      pop1();
      chk("timing_pop_empty", 32'(empty), 32'd1);

      for (int i = 0; i < 9; i++) begin
         fe_cycles = 0;
         if (vecs[i].send) begin
            send_frame(vecs[i].data, vecs[i].stop_b, 0, -1, -1, 1'b0);
            idle(6);
         end
         if (vecs[i].pop) pop1();
         chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_fe", i), 32'(fe_cycles), 32'(vecs[i].exp_fe));
      end

      // Glitch shorter than half a bit
      busy_seen = 0;
      rx = 1'b0;
      repeat (5) step();
      idle(20);
      chk("glitch_busy_seen", 32'(busy_seen > 0), 32'd1);
      chk("glitch_busy_end", 32'(busy), 32'd0);
      chk("glitch_count", 32'(count), 32'd0);

      // Bad stop bit followed by a held-low line
      fe_cycles = 0;
      send_frame(8'h3C, 1'b0, 5 * B, -1, -1, 1'b0);
      chk("ferr_pulses", 32'(fe_cycles), 32'd1);
      chk("ferr_busy_low", 32'(busy), 32'd1);
      chk("ferr_count", 32'(count), 32'd0);
      idle(6);
      chk("ferr_busy_after", 32'(busy), 32'd0);
      send_frame(8'h11, 1'b1, 0, -1, -1, 1'b0);
      idle(6);
      chk("ferr_next_rd", 32'(rd_data), 32'h11);
      chk("ferr_next_count", 32'(count), 32'd1);
      pop1();

      // Fill and overflow
      for (int b = 0; b < 17; b++) begin
         send_frame(8'(b), 1'b1, 0, -1, -1, 1'b0);
         idle(4);
         if (b == 15) begin
            chk("fill_full16", 32'(full), 32'd1);
            chk("fill_ovf16", 32'(overflow), 32'd0);
         end
      end
      chk("fill_ovf17", 32'(overflow), 32'd1);
      chk("fill_count17", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fill_pop%0d", i), 32'(rd_data), 32'(i));
         pop1();
      end
      chk("fill_drained", 32'(empty), 32'd1);
      chk("fill_ovf_sticky", 32'(overflow), 32'd1);
      clear_errors = 1'b1;
      step();
      clear_errors = 1'b0;
      chk("fill_ovf_cleared", 32'(overflow), 32'd0);

      // Push and pop on the same edge while full
      for (int b = 0; b < 16; b++) begin
         send_frame(8'h20 + 8'(b), 1'b1, 0, -1, -1, 1'b0);
         idle(4);
      end
      send_frame(8'h30, 1'b1, 0, 154, -1, 1'b0);
      idle(4);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_count", 32'(count), 32'd16);
      chk("pp_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("pp_pop%0d", i), 32'(rd_data), 32'h21 + 32'(i));
         pop1();
      end
      chk("pp_drained", 32'(empty), 32'd1);

      // Reset in the middle of data bit 4
      for (int b = 0; b < 3; b++) begin
         send_frame(8'h41 + 8'(b), 1'b1, 0, -1, -1, 1'b0);
         idle(4);
      end
      chk("mid_count3", 32'(count), 32'd3);
      send_frame(8'h99, 1'b1, 0, -1, 88, 1'b0);
      rx = 1'b1;
      reset = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (3) step();
      reset = 1'b1;
      idle(4);
      send_frame(8'h96, 1'b1, 0, -1, -1, 1'b0);
      idle(4);
      chk("midrst_next_rd", 32'(rd_data), 32'h96);
      chk("midrst_next_count", 32'(count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
